// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding, baud divider helper and parameter limits.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 4;

    function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-cycle tick every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= (cnt == TOP) ? '0 : cnt + 1'b1;

    assign tick = cnt == TOP;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver, 5..9 data bits, valid/ready output with overrun.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd/even).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [SW-1:0] HALF  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam uart_state_t AFTER_DATA = ST_PARITY;
    localparam logic ODD = 1'(PARITY_ODD);
`else
    localparam uart_state_t AFTER_DATA = ST_STOP;
`endif

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX || OVERSAMPLE < OVERSAMPLE_MIN ||
        OVERSAMPLE % 2 != 0 || DIV < 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_param: parameter out of range");
    end

    logic                 tick, s1, s2, prev, fall, sample, load, hold_old;
    uart_state_t          state;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign fall     = prev && !s2;
    assign sample   = tick && scnt == (state == ST_START ? HALF : LAST);
    assign load     = sample && state == ST_STOP;
    assign hold_old = rx_valid && !rx_ready;
    assign busy     = state != ST_IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {prev, s2, s1} <= 3'b111;
        else        {prev, s2, s1} <= {s2, s1, rxd};

    // Half-bit sample in START realigns the counter so every later sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= ST_IDLE;
            scnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            if (state == ST_IDLE) scnt <= '0;
            else if (tick)        scnt <= sample ? '0 : scnt + 1'b1;
            case (state)
                ST_IDLE:  if (fall) state <= ST_START;
                ST_START: if (sample) begin
                    state <= s2 ? ST_IDLE : ST_DATA;
                    bcnt  <= '0;
                end
                ST_DATA:  if (sample) begin
                    shreg <= {s2, shreg[DATA_BITS-1:1]};
                    bcnt  <= bcnt + 1'b1;
                    if (bcnt == BLAST) state <= AFTER_DATA;
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: if (sample) state <= ST_STOP;
`endif
                ST_STOP:  if (sample) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                               par_bad <= 1'b0;
        else if (sample && state == ST_PARITY)    par_bad <= s2 ^ (^shreg) ^ ODD;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                parity_err <= 1'b0;
        else if (load && !hold_old) parity_err <= par_bad;
`else
    assign parity_err = 1'b0;
`endif

    // A new frame arriving over an unaccepted one is dropped; the old word stays visible.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= load && hold_old;
            if (load && !hold_old) begin
                rx_data   <= shreg;
                frame_err <= !s2;
                rx_valid  <= 1'b1;
            end else if (rx_ready) rx_valid <= 1'b0;
        end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized and directed frames against a queue-based delivery model.
module tb_uart_rx_param;

    localparam int DB  = 8;
    localparam int BIT = 32;
    localparam int ODD = 0;

    logic          clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_err, parity_err, overrun, busy;

    int         vectors = 0, miscompares = 0, ovr_cnt = 0, xfer_cnt = 0;
    logic [9:0] exp_q[$];

    uart_rx_param #(
        .CLK_FREQ  (50_000_000),
        .BAUD      (1_562_500),
        .OVERSAMPLE(16),
        .DATA_BITS (DB),
        .PARITY_ODD(ODD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Every accepted word must match the oldest frame the model says is deliverable.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n) begin
            if (overrun) ovr_cnt++;
            if (rx_valid && rx_ready) begin
                xfer_cnt++;
                check("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rx_data", rx_data, e[7:0]);
                    check("frame_err", frame_err, e[9]);
                    check("parity_err", parity_err, e[8]);
                end
            end
        end
    end

    task automatic hold(input logic b, input int n);
        rxd = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit stop, input bit pflip, input bit push, input bit lat);
        bit perr;
`ifdef UART_RX_PARITY_EN
        perr = pflip;
`else
        perr = 1'b0;
`endif
        if (push) exp_q.push_back({!stop, perr, d});
        if (lat) begin
            rxd = 1'b0;
            repeat (2) @(posedge clk);
            #1 check("busy_before_3clk", busy, 0);
            @(posedge clk);
            #1 check("busy_at_3clk", busy, 1);
            hold(0, BIT - 3);
        end else hold(0, BIT);
        for (int i = 0; i < DB; i++) hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ 1'(ODD) ^ pflip, BIT);
`endif
        hold(stop, BIT);
        if (!stop) hold(1, BIT);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  x0, o0, n;
        bit  saw;
        #1;
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        hold(1, 20);

        send(8'hA5, 1, 0, 1, 1);
        hold(1, 10);
        check("a5_delivered", xfer_cnt, 1);

        x0 = xfer_cnt;
        hold(0, 2);
        rxd = 1'b1;
        saw = 1'b0;
        for (n = 0; n < 18 && !(saw && !busy); n++) begin
            @(posedge clk);
            #1 if (busy) saw = 1'b1;
        end
        check("glitch_busy_seen", saw, 1);
        check("glitch_busy_clear", busy, 0);
        hold(1, 40);
        check("glitch_no_frame", xfer_cnt, x0);

        send(8'h3C, 0, 0, 1, 0);
        send(8'h55, 1, 0, 1, 0);
        hold(1, 10);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1, 0, 1, 0);
        send(8'h07, 1, 1, 1, 0);
        hold(1, 10);
`endif

        exp_q.push_back(10'h200);
        hold(0, BIT * 12);
        hold(1, BIT * 2);
        check("break_once", exp_q.size(), 0);

        o0 = ovr_cnt;
        x0 = xfer_cnt;
        rx_ready = 1'b0;
        send(8'h11, 1, 0, 1, 0);
        send(8'h22, 1, 0, 0, 0);
        hold(1, 8);
        check("ovr_pulse_once", ovr_cnt - o0, 1);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_no_xfer", xfer_cnt, x0);
        rx_ready = 1'b1;
        hold(1, 2);
        check("ovr_xfer", xfer_cnt - x0, 1);
        check("ovr_valid_fall", rx_valid, 0);

        hold(0, BIT);
        for (int i = 0; i < 4; i++) hold(1'(i % 2), BIT);
        hold(1'b0, BIT / 2);
        rst_n = 1'b0;
        rxd = 1'b1;
        #1;
        check("midrst_rx_data", rx_data, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_parity_err", parity_err, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hold(1, 40);
        check("midrst_no_frame", rx_valid, 0);
        send(8'hC3, 1, 0, 1, 0);
        hold(1, 10);

        for (int k = 0; k < 24; k++) begin
            bit pf;
`ifdef UART_RX_PARITY_EN
            pf = $urandom_range(0, 3) == 0;
`else
            pf = 1'b0;
`endif
            send(8'($urandom), $urandom_range(0, 4) != 0, pf, 1, 0);
            hold(1, $urandom_range(0, 40));
        end
        hold(1, 10);

        check("scoreboard_drained", exp_q.size(), 0);
        check("total_overruns", ovr_cnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
